// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter sharing a 4:1 two-bit channel multiplexer between four
// requesters A, B, C and D. The winner's one-hot grant and the mux selects
// are registered one cycle after the request is seen. While a requester
// holds the grant, its data pair is captured onto F0/F1 every cycle, and
// Valid marks each captured word. A tenure lasts at most MAX_HOLD words
// while another requester is waiting. Every release passes through one IDLE
// cycle with Gnt=0000 before the next grant.
//
// Parameters:
//   MAX_HOLD  maximum consecutive words per tenure under contention (1..15)
//   CNT_W     width of the hold counter; 2**CNT_W must exceed MAX_HOLD
//
// Ports:
//   Clk            in   system clock; all logic updates on the rising edge
//   Rst_n          in   synchronous active-low reset
//   Req[3:0]       in   request lines; bit0=A, bit1=B, bit2=C, bit3=D
//   A0..D1         in   per-requester data pairs (x0, x1)
//   Gnt[3:0]       out  registered one-hot grant (all-zero when idle)
//   S0, S1         out  registered mux select; {S0,S1}: 00=A 01=B 10=C 11=D
//   F0, F1         out  registered data pair taken from the granted requester
//   Valid          out  F0/F1 hold a word captured from the granted requester
//   Lock           in   only when MUX_ARB_LOCK_EN is defined; suppresses
//                       MAX_HOLD preemption while the owner keeps requesting
//
// Optional feature macro: MUX_ARB_LOCK_EN
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [3:0] Req,
   input  logic       A0,
   input  logic       A1,
   input  logic       B0,
   input  logic       B1,
   input  logic       C0,
   input  logic       C1,
   input  logic       D0,
   input  logic       D1,
   output logic [3:0] Gnt,
   output logic       S0,
   output logic       S1,
   output logic       F0,
   output logic       F1,
   output logic       Valid
`ifdef MUX_ARB_LOCK_EN
   ,
   input  logic       Lock
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       gidx_q, gidx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       gnt_d;
   logic             s0_d, s1_d;
   logic             f0_d, f1_d;
   logic             valid_d;

   logic [3:0]       bit0_bus;
   logic [3:0]       bit1_bus;
   logic [1:0]       pick_idx;
   logic [1:0]       scan_idx;
   logic [3:0]       owner_mask;
   logic             others_pending;
   logic             hold_expired;
   logic             lock_hold;

   // Gather the data pairs so the owner's pair can be picked out by index.
   assign bit0_bus = {D0, C0, B0, A0};
   assign bit1_bus = {D1, C1, B1, A1};

`ifdef MUX_ARB_LOCK_EN
   assign lock_hold = Lock;
`else
   assign lock_hold = 1'b0;
`endif

   // Other waiting requesters are what make a full hold counter force a release.
   assign owner_mask     = 4'b0001 << gidx_q;
   assign others_pending = |(Req & ~owner_mask);
   assign hold_expired   = (cnt_q == CNT_W'(MAX_HOLD));

   // Circular priority scan starting at the pointer. The loop runs from the
   // farthest offset to the nearest, so the nearest set bit is written last
   // and wins.
   always_comb begin
      pick_idx = ptr_q;
      scan_idx = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         scan_idx = ptr_q + 2'(i);
         if (Req[scan_idx]) begin
            pick_idx = scan_idx;
         end
      end
   end

   // Next-state and next-output logic. Every register holds by default. Only
   // IDLE can start a tenure, and only GRANT can end one, so S0/S1 move only
   // on a new grant.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      cnt_d   = cnt_q;
      gnt_d   = Gnt;
      s0_d    = S0;
      s1_d    = S1;
      f0_d    = F0;
      f1_d    = F1;
      valid_d = Valid;

      case (state_q)
         IDLE: begin
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            if (|Req) begin
               gidx_d  = pick_idx;
               gnt_d   = 4'b0001 << pick_idx;
               s0_d    = pick_idx[1];
               s1_d    = pick_idx[0];
               cnt_d   = CNT_W'(1);
               state_d = GRANT;
            end
         end

         GRANT: begin
            if (!Req[gidx_q]) begin
               // The owner has gone away. Nothing is captured, and the turn
               // passes to the next requester in circular order.
               valid_d = 1'b0;
               gnt_d   = 4'b0000;
               ptr_d   = gidx_q + 2'd1;
               state_d = IDLE;
            end else begin
               f0_d    = bit0_bus[gidx_q];
               f1_d    = bit1_bus[gidx_q];
               valid_d = 1'b1;
               if (hold_expired) begin
                  // The last word is still captured on a preemption. With no
                  // contender, or with Lock set, the counter saturates.
                  if (others_pending && !lock_hold) begin
                     gnt_d   = 4'b0000;
                     ptr_d   = gidx_q + 2'd1;
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset is synchronous and wins over
   // everything, including a transfer in progress.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         gidx_q  <= 2'd0;
         cnt_q   <= '0;
         Gnt     <= 4'b0000;
         S0      <= 1'b0;
         S1      <= 1'b0;
         F0      <= 1'b0;
         F1      <= 1'b0;
         Valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         cnt_q   <= cnt_d;
         Gnt     <= gnt_d;
         S0      <= s0_d;
         S1      <= s1_d;
         F0      <= f0_d;
         F1      <= f1_d;
         Valid   <= valid_d;
      end
   end

endmodule
